// File: rtl/hcsr04_echo_emulator.sv
// HC-SR04 ultrasonic sensor stand-in.
// A valid trigger pulse is answered, after a fixed burst delay, by an echo
// pulse whose width in ticks encodes the programmed target distance. A quiet
// holdoff window follows each echo before the next ping is accepted.
module hcsr04_echo_emulator #(
    parameter int unsigned TRIG_MIN       = 1,
    parameter int unsigned BURST_CYCLES   = 20,
    parameter int unsigned TIMEOUT_CYCLES = 3800,
    parameter int unsigned HOLDOFF_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic        enable,
    input  logic        obj_present,
    input  logic [11:0] echo_width,
    output logic        echo,
    output logic        busy,
    output logic        trig_err,
    output logic [7:0]  ping_count,
    output logic [2:0]  PS
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TRIG    = 3'd1;
    localparam logic [2:0] BURST   = 3'd2;
    localparam logic [2:0] ECHO    = 3'd3;
    localparam logic [2:0] HOLDOFF = 3'd4;

    localparam logic [15:0] TRIG_MIN_C   = 16'(TRIG_MIN);
    localparam logic [15:0] BURST_LAST   = 16'(BURST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_C    = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] HOLDOFF_LAST = 16'(HOLDOFF_CYCLES - 1);

    logic        trig_d;
    logic        trig_rise;
    logic [15:0] cnt;
    logic [15:0] w_lat;
    logic [15:0] w_sel;
    logic [15:0] w_clamped;

    assign trig_rise = trigger & ~trig_d;
    assign busy      = (PS != IDLE);

    // Delay the trigger by one tick so a held-high trigger is not a new ping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_d <= 1'b0;
        end else begin
            trig_d <= trigger;
        end
    end

    // Pick the echo width for the next ping and keep it within [1, timeout].
    always_comb begin
        w_sel = obj_present ? {4'd0, echo_width} : TIMEOUT_C;
        if (w_sel == 16'd0) begin
            w_clamped = 16'd1;
        end else if (w_sel > TIMEOUT_C) begin
            w_clamped = TIMEOUT_C;
        end else begin
            w_clamped = w_sel;
        end
    end

    // Ping sequencer: trigger qualification, burst delay, echo, holdoff.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PS         <= IDLE;
            echo       <= 1'b0;
            trig_err   <= 1'b0;
            ping_count <= 8'd0;
            cnt        <= 16'd0;
            w_lat      <= 16'd0;
        end else begin
            trig_err <= 1'b0;
            if (!enable) begin
                PS   <= IDLE;
                echo <= 1'b0;
                cnt  <= 16'd0;
            end else begin
                case (PS)
                    IDLE: begin
                        if (trig_rise) begin
                            PS  <= TRIG;
                            cnt <= 16'd1;
                        end
                    end
                    TRIG: begin
                        if (trigger) begin
                            if (cnt != 16'hFFFF) begin
                                cnt <= cnt + 16'd1;
                            end
                        end else if (cnt >= TRIG_MIN_C) begin
                            PS         <= BURST;
                            cnt        <= 16'd0;
                            ping_count <= ping_count + 8'd1;
                            w_lat      <= w_clamped;
                        end else begin
                            trig_err <= 1'b1;
                            PS       <= IDLE;
                            cnt      <= 16'd0;
                        end
                    end
                    BURST: begin
                        if (cnt == BURST_LAST) begin
                            PS   <= ECHO;
                            cnt  <= 16'd0;
                            echo <= 1'b1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    ECHO: begin
                        if (cnt == w_lat - 16'd1) begin
                            PS   <= HOLDOFF;
                            cnt  <= 16'd0;
                            echo <= 1'b0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    HOLDOFF: begin
                        if (cnt == HOLDOFF_LAST) begin
                            PS  <= IDLE;
                            cnt <= 16'd0;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    default: begin
                        PS   <= IDLE;
                        echo <= 1'b0;
                        cnt  <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// Directed bench for the HC-SR04 echo emulator. A second instance with a
// longer minimum trigger width covers short-trigger rejection.
`timescale 1us/1ns
module tb_hcsr04_echo_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trigger = 1'b0;
    logic        trigger2 = 1'b0;
    logic        enable = 1'b1;
    logic        obj_present = 1'b1;
    logic [11:0] echo_width = 12'd100;

    logic        echo, busy, trig_err;
    logic [7:0]  ping_count;
    logic [2:0]  PS;
    logic        echo2, busy2, trig_err2;
    logic [7:0]  ping_count2;
    logic [2:0]  PS2;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;

    // 100 kHz clock: 10 us period.
    always #5 clk = ~clk;

    hcsr04_echo_emulator dut (
        .clk(clk), .rst(rst), .trigger(trigger), .enable(enable),
        .obj_present(obj_present), .echo_width(echo_width),
        .echo(echo), .busy(busy), .trig_err(trig_err),
        .ping_count(ping_count), .PS(PS)
    );

    hcsr04_echo_emulator #(.TRIG_MIN(2)) dut2 (
        .clk(clk), .rst(rst), .trigger(trigger2), .enable(enable),
        .obj_present(obj_present), .echo_width(echo_width),
        .echo(echo2), .busy(busy2), .trig_err(trig_err2),
        .ping_count(ping_count2), .PS(PS2)
    );

    // Record any trig_err pulse from the main instance.
    always @(negedge clk) if (trig_err === 1'b1) err_seen++;

    // Advance past the next rising edge and settle.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle trigger pulse on the main instance.
    task automatic applyStimulus();
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
    endtask

    // Count edges until echo reaches lvl, giving up at limit.
    task automatic waitEcho(input logic lvl, input int limit, output int n);
        n = 0;
        while (echo !== lvl && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    task automatic waitIdle(input int limit, output int n);
        n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    // Full ping: delay to echo rise, echo width, holdoff length.
    task automatic runPing(output int dly, output int hi, output int hold);
        applyStimulus();
        waitEcho(1'b1, 100, dly);
        waitEcho(1'b0, 5000, hi);
        waitIdle(3000, hold);
    endtask

    initial begin
        int n, dly, hi, hold;

        // Reset state
        tick(2);
        checkOutput("rst_ps", PS, 0);
        checkOutput("rst_echo", echo, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_trig_err", trig_err, 0);
        checkOutput("rst_ping_count", ping_count, 0);
        rst = 1'b0;
        tick(2);

        // Single-cycle trigger, width 100
        obj_present = 1'b1;
        echo_width  = 12'd100;
        trigger = 1'b1;
        tick(1);
        checkOutput("t1_trig_state", PS, 1);
        trigger = 1'b0;
        waitEcho(1'b1, 100, n);
        checkOutput("t1_echo_delay", n, 21);
        checkOutput("t1_ping_count", ping_count, 1);
        checkOutput("t1_busy", busy, 1);
        waitEcho(1'b0, 5000, n);
        checkOutput("t1_echo_width", n, 100);
        waitIdle(3000, n);
        checkOutput("t1_holdoff", n, 1000);

        // No object: timeout width; oversized width clamps; zero gives one tick
        obj_present = 1'b0;
        echo_width  = 12'd50;
        runPing(dly, hi, hold);
        checkOutput("t2_noobj_delay", dly, 21);
        checkOutput("t2_noobj_width", hi, 3800);
        obj_present = 1'b1;
        echo_width  = 12'd4000;
        runPing(dly, hi, hold);
        checkOutput("t2_clamp_width", hi, 3800);
        echo_width  = 12'd0;
        runPing(dly, hi, hold);
        checkOutput("t2_zero_width", hi, 1);
        checkOutput("t2_zero_holdoff", hold, 1000);
        checkOutput("t2_ping_count", ping_count, 4);

        // Short trigger rejected on the TRIG_MIN=2 instance, then a valid one
        trigger2 = 1'b1;
        tick(1);
        trigger2 = 1'b0;
        tick(1);
        checkOutput("t3_trig_err", trig_err2, 1);
        checkOutput("t3_ps_idle", PS2, 0);
        checkOutput("t3_ping_kept", ping_count2, 0);
        tick(1);
        checkOutput("t3_trig_err_clear", trig_err2, 0);
        checkOutput("t3_echo_low", echo2, 0);
        trigger2 = 1'b1;
        tick(2);
        trigger2 = 1'b0;
        tick(1);
        checkOutput("t3_valid_state", PS2, 2);
        checkOutput("t3_valid_count", ping_count2, 1);
        checkOutput("t3_no_err", trig_err2, 0);

        // Trigger activity during BURST, ECHO, HOLDOFF is ignored
        echo_width = 12'd100;
        applyStimulus();
        tick(5);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        waitEcho(1'b1, 100, n);
        checkOutput("t4_delay", n + 6, 21);
        tick(10);
        trigger = 1'b1;
        tick(2);
        trigger = 1'b0;
        waitEcho(1'b0, 5000, n);
        checkOutput("t4_width", n + 12, 100);
        tick(100);
        trigger = 1'b1;
        waitIdle(3000, n);
        checkOutput("t4_holdoff", n + 100, 1000);
        tick(5);
        checkOutput("t4_held_trig_idle", PS, 0);
        checkOutput("t4_ping_once", ping_count, 5);
        checkOutput("t4_no_err", err_seen, 0);
        trigger = 1'b0;
        tick(1);
        trigger = 1'b1;
        tick(1);
        checkOutput("t4_fresh_rise", PS, 1);
        trigger = 1'b0;
        enable  = 1'b0;
        tick(1);
        enable  = 1'b1;
        checkOutput("t4_abort_idle", PS, 0);
        checkOutput("t4_abort_count", ping_count, 5);

        // Width change mid-echo does not affect the pulse in flight
        echo_width = 12'd100;
        applyStimulus();
        waitEcho(1'b1, 100, n);
        tick(20);
        echo_width = 12'd300;
        waitEcho(1'b0, 5000, n);
        checkOutput("t5_inflight_width", n + 20, 100);
        waitIdle(3000, n);
        runPing(dly, hi, hold);
        checkOutput("t5_next_width", hi, 300);

        // Reset mid-echo drops everything at once
        echo_width = 12'd100;
        applyStimulus();
        waitEcho(1'b1, 100, n);
        tick(10);
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_echo", echo, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_ps", PS, 0);
        checkOutput("t6_rst_count", ping_count, 0);
        tick(1);
        rst = 1'b0;
        tick(5);
        checkOutput("t6_wait_fresh", PS, 0);

        // enable low mid-BURST aborts without an echo
        applyStimulus();
        tick(6);
        checkOutput("t6_burst", PS, 2);
        enable = 1'b0;
        tick(1);
        checkOutput("t6_disable_idle", PS, 0);
        enable = 1'b1;
        tick(25);
        checkOutput("t6_no_echo", echo, 0);
        checkOutput("t6_count_kept", ping_count, 1);

        // ping_count wrap via short aborted pings
        for (int i = 0; i < 255; i++) begin
            applyStimulus();
            tick(1);
            enable = 1'b0;
            tick(1);
            enable = 1'b1;
            if (i == 253) checkOutput("t6_count_255", ping_count, 255);
        end
        checkOutput("t6_count_wrap", ping_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

endmodule
